// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, valid/ready on both sides.
// Define SEQ_MULTIPLIER_SIGNED_EN to add the signed_mode input (two's-complement operands).
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic                 signed_mode,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   sum;
    logic                 cap_signed;
    logic                 neg_step;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic                 signed_q, signed_d;

    assign cap_signed = signed_mode;
    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so that step subtracts.
    assign neg_step   = signed_q && (cnt_q == CntLast);
`else
    assign cap_signed = 1'b0;
    assign neg_step   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum         = acc_q;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        signed_d    = signed_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d    = {{WIDTH{cap_signed & A[WIDTH-1]}}, A};
                    mplier_d   = B;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                    signed_d   = signed_mode;
`endif
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    sum = neg_step ? (acc_q - mcand_q) : (acc_q + mcand_q);
                end
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    p_d         = sum;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    p_d         = '0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                p_d         = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            signed_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            signed_q    <= signed_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a WIDTH=4 and a WIDTH=8 instance sharing clock and reset.
// Signed cases run only when SEQ_MULTIPLIER_SIGNED_EN is defined.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv4, ir4, ov4, or4, sm4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        iv8, ir8, ov8, or8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;
    int sb4[$];
    int sb8[$];

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .signed_mode(sm4),
`endif
        .in_valid  (iv4),
        .in_ready  (ir4),
        .A         (a4),
        .B         (b4),
        .out_valid (ov4),
        .out_ready (or4),
        .P         (p4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .signed_mode(sm8),
`endif
        .in_valid  (iv8),
        .in_ready  (ir8),
        .A         (a8),
        .B         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .P         (p8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Product is checked on every handshake; P must read zero whenever out_valid is low.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov4 && or4) begin
                if (sb4.size() == 0) check_eq("sb4_unexpected_output", 32'd1, 32'd0);
                else check_eq("p4", {24'd0, p4}, sb4.pop_front());
            end
            if (!ov4) check_eq("p4_zero_when_invalid", {24'd0, p4}, 32'd0);
            if (ov8 && or8) begin
                if (sb8.size() == 0) check_eq("sb8_unexpected_output", 32'd1, 32'd0);
                else check_eq("p8", {16'd0, p8}, sb8.pop_front());
            end
            if (!ov8) check_eq("p8_zero_when_invalid", {16'd0, p8}, 32'd0);
        end
    end

    // One WIDTH=4 operation with out_ready held high; operands are scrambled while busy.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm, input int exp);
        int cyc;
        int lat;
        cyc = 0;
        while (!ir4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("ir4_ready_before_op", {31'd0, ir4}, 32'd1);
        a4  = a;
        b4  = b;
        sm4 = sm;
        iv4 = 1'b1;
        sb4.push_back(exp);
        @(posedge clk); #1;
        iv4 = 1'b0;
        sm4 = ~sm;
        cyc = 0;
        lat = -1;
        while (cyc < 40) begin
            if (ov4 && lat < 0) lat = cyc;
            if (ir4) break;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("lat4", lat, 32'd4);
        check_eq("in_ready4_low_cycles", cyc, 32'd5);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1; sm4 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0; sm8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ir4", {31'd0, ir4}, 32'd1);
        check_eq("rst_ov4", {31'd0, ov4}, 32'd0);
        check_eq("rst_p4", {24'd0, p4}, 32'd0);
        check_eq("rst_ir8", {31'd0, ir8}, 32'd1);
        check_eq("rst_p8", {16'd0, p8}, 32'd0);
        rst = 1'b0;

        op4(4'd3, 4'd5, 1'b0, 15);

        for (int i = 0; i < 256; i++) begin
            op4(4'(i >> 4), 4'(i), 1'b0, (i >> 4) * (i & 15));
        end

        // Long stall on the WIDTH=8 instance with all-ones operands.
        a8 = 8'd255;
        b8 = 8'd255;
        iv8 = 1'b1;
        sb8.push_back(65025);
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        cyc = 0;
        while (!ov8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("lat8", cyc, 32'd8);
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_p8", {16'd0, p8}, 32'd65025);
            check_eq("hold_ov8", {31'd0, ov8}, 32'd1);
            check_eq("hold_ir8", {31'd0, ir8}, 32'd0);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        check_eq("release_ir8", {31'd0, ir8}, 32'd1);
        check_eq("release_ov8", {31'd0, ov8}, 32'd0);

        // Reset two cycles into a WIDTH=4 operation, then accept right after release.
        a4 = 4'd9;
        b4 = 4'd11;
        iv4 = 1'b1;
        sb4.push_back(99);
        @(posedge clk); #1;
        iv4 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_eq("midrst_ov4", {31'd0, ov4}, 32'd0);
        check_eq("midrst_ir4", {31'd0, ir4}, 32'd1);
        check_eq("midrst_p4", {24'd0, p4}, 32'd0);
        sb4.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        op4(4'd6, 4'd7, 1'b0, 42);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        op4(4'hF, 4'hF, 1'b1, 32'h01);
        op4(4'h8, 4'h7, 1'b1, 32'hC8);
        op4(4'h8, 4'h8, 1'b1, 32'h40);
        op4(4'hF, 4'hF, 1'b0, 225);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb4_drained", sb4.size(), 32'd0);
        check_eq("sb8_drained", sb8.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have localparam CNT_W, value $clog2(WIDTH)+1, meaning bit-counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  meaning operands A/B are valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  meaning multiplicand.
REQ-008 SHALL have port B  input  WIDTH  meaning multiplier.
REQ-009 SHALL have port out_valid  output  1  meaning P holds a completed product.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer accepts P.
REQ-011 SHALL have port P  output  2*WIDTH  meaning the product.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL capture A and B on the edge where in_valid && in_ready, clear the accumulator and counter, and enter BUSY.
REQ-015 SHALL, in BUSY, process one multiplier bit per cycle, LSB first: add the shifted multiplicand to the 2*WIDTH accumulator when the bit is 1, then shift.
REQ-016 SHALL leave BUSY for DONE on the WIDTH-th BUSY edge, giving out_valid high exactly WIDTH cycles after the accept edge, independent of operand values.
REQ-017 SHALL hold out_valid=1 and P stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-018 SHALL allow out_ready high in advance, so the product is consumed on the first DONE cycle.
REQ-019 SHALL ignore in_valid, A and B outside IDLE; operand changes after capture SHALL NOT affect the result.
REQ-020 SHALL produce the exact unsigned product with no overflow (2*WIDTH result); 0 operands and all-ones operands SHALL take the same latency.
REQ-021 SHALL drive P=0 whenever out_valid=0.

Reset
REQ-022 SHALL, on rst=1 at any time including mid-BUSY or in DONE, immediately force state=IDLE, in_ready=1, out_valid=0, P=0, and clear the accumulator, operand registers and counter.
REQ-023 SHALL accept a new operation on the first rising edge after rst deasserts if in_valid=1.

Configuration
REQ-024 SHALL support macro SEQ_MULTIPLIER_SIGNED_EN.
REQ-025 SHALL, with SEQ_MULTIPLIER_SIGNED_EN defined, add input signed_mode (1 bit, sampled at accept); when 1, A and B are two's complement and P is the sign-correct 2*WIDTH two's-complement product, with latency unchanged.
REQ-026 SHALL, without the macro, have no signed_mode port and perform unsigned multiplication only.

Structure
REQ-027 SHALL place the FSM state enum typedef (IDLE/BUSY/DONE) in shared package mult_pkg.
REQ-028 SHALL be a single module with no sub-modules; the add/shift datapath stays inline.

Verification
REQ-029 SHALL verify WIDTH=4, A=3, B=5 accepted at edge k -> out_valid high after edge k+4, P=15.
REQ-030 SHALL verify WIDTH=4 exhaustive sweep of 256 pairs with out_ready=1 -> every P equals A*B and in_ready drops for exactly 5 cycles per operation.
REQ-031 SHALL verify WIDTH=8, A=255, B=255, out_ready=0 for 10 cycles -> P=65025 held stable with out_valid=1 and in_ready=0 throughout, IDLE one edge after out_ready=1.
REQ-032 SHALL verify rst pulsed 2 cycles after accept -> out_valid=0 and in_ready=1 immediately; a following 6*7 completes with P=42.
REQ-033 SHALL verify A/B changed during BUSY -> P reflects only the captured operands.
REQ-034 SHALL verify, with SEQ_MULTIPLIER_SIGNED_EN and WIDTH=4, signed_mode=1: A=-1 (4'hF), B=-1 -> P=1; A=-8, B=7 -> P=-56 (8'hC8).
